line_filter: RTL and testbench

Parametrised multi-channel debouncer/glitch filter for the controller-side input lines. Each channel is synchronised, then its output changes only after THRESH consecutive sampled values that disagree with the current output. Each channel also produces one-cycle rise and fall strobes for downstream protocol logic. A shared sample tick and a hold input let the controller bridge decimate or freeze filtering during its own transmit windows.

---
 rtl/line_filter.sv | 54 +++++
 tb/tb_line_filter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/line_filter.sv
// line_filter: per-channel synchroniser and debounce filter with rise/fall strobes.
// Outputs flip only after THRESH consecutive ticked samples disagree with them.
module line_filter #(
   parameter int CHANNELS    = 1,
   parameter int THRESH      = 8,
   parameter int SYNC_STAGES = 2,
   parameter bit INIT        = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] line,
   input  logic                tick,
   input  logic                hold,
   output logic [CHANNELS-1:0] debounced,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_change
);
   localparam int CW = $clog2(THRESH + 1);
   logic [CHANNELS-1:0] s;
   logic [CHANNELS-1:0] flip;
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [CW-1:0] cnt;
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s[c] = line[c];
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sr;
         always_ff @(posedge clk)
            sr <= rst ? {SYNC_STAGES{INIT}} : SYNC_STAGES'({sr, line[c]});
         assign s[c] = sr[SYNC_STAGES-1];
      end
      assign flip[c] = tick & ~hold & (s[c] ^ debounced[c]) & (cnt == CW'(THRESH - 1));
      // Agreement or an accepted flip restarts the run; the increment saturates.
      always_ff @(posedge clk) begin
         if (rst || hold)
            cnt <= '0;
         else if (tick)
            cnt <= (s[c] == debounced[c] || flip[c]) ? '0 : (&cnt ? cnt : cnt + CW'(1));
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         debounced  <= {CHANNELS{INIT}};
         rise       <= '0;
         fall       <= '0;
         any_change <= 1'b0;
      end else begin
         debounced  <= debounced ^ flip;
         rise       <= flip & s;
         fall       <= flip & ~s;
         any_change <= |flip;
      end
   end
endmodule

// File: tb/tb_line_filter.sv
// tb_line_filter: directed and random stimulus against a sample-history reference model.
module tb_line_filter;
   localparam int CH = 4;
   localparam int TH = 8;
   localparam int SS = 2;
   logic clk = 1'b0;
   logic rst, tick, hold, any_change;
   logic [CH-1:0] line, debounced, rise, fall;
   int checks = 0;
   int errors = 0;
   logic [CH-1:0] m_deb, m_rise, m_fall;
   logic m_any;
   logic [CH-1:0] pipe[$];
   bit hist[CH][$];

   line_filter #(.CHANNELS(CH), .THRESH(TH), .SYNC_STAGES(SS), .INIT(1'b0)) u_dut (
      .clk(clk), .rst(rst), .line(line), .tick(tick), .hold(hold),
      .debounced(debounced), .rise(rise), .fall(fall), .any_change(any_change)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // A channel flips when its last TH ticked samples all differ from its output.
   task automatic model_edge(input logic r, input logic [CH-1:0] l, input logic t, input logic h);
      logic [CH-1:0] sv;
      bit ok;
      m_rise = '0;
      m_fall = '0;
      if (r) begin
         pipe.delete();
         repeat (SS) pipe.push_back('0);
         m_deb = '0;
         for (int c = 0; c < CH; c++) hist[c].delete();
      end else begin
         sv = pipe[0];
         if (h) begin
            for (int c = 0; c < CH; c++) hist[c].delete();
         end else if (t) begin
            for (int c = 0; c < CH; c++) begin
               hist[c].push_back(sv[c]);
               if (hist[c].size() > TH) void'(hist[c].pop_front());
               ok = (hist[c].size() == TH);
               foreach (hist[c][i]) if (hist[c][i] == m_deb[c]) ok = 0;
               if (ok) begin
                  m_deb[c] = ~m_deb[c];
                  if (m_deb[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
                  hist[c].delete();
               end
            end
         end
         void'(pipe.pop_front());
         pipe.push_back(l);
      end
      m_any = |(m_rise | m_fall);
   endtask

   task automatic step(input logic r, input logic [CH-1:0] l, input logic t, input logic h);
      rst = r;
      line = l;
      tick = t;
      hold = h;
      @(posedge clk);
      model_edge(r, l, t, h);
      #1;
      chk("debounced", debounced, m_deb);
      chk("rise", rise, m_rise);
      chk("fall", fall, m_fall);
      chk("any_change", {3'b000, any_change}, {3'b000, m_any});
   endtask

   initial begin
      int n, nf;
      logic [CH-1:0] rl;
      // Reset with all lines high, then latency to first flip
      repeat (3) begin
         step(1'b1, 4'hF, 1'b1, 1'b0);
         chk("rst_deb", debounced, 4'h0);
         chk("rst_rise", rise, 4'h0);
      end
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 4'hF, 1'b1, 1'b0);
         if (i == 9) chk("lat_pre", debounced, 4'h0);
         if (i == 10) begin
            chk("lat_deb", debounced, 4'hF);
            chk("lat_rise", rise, 4'hF);
            chk("lat_any", {3'b000, any_change}, 4'h1);
         end
         if (i == 11) chk("lat_rise_off", rise, 4'h0);
      end
      repeat (12) step(1'b0, 4'h0, 1'b1, 1'b0);
      chk("settle_low", debounced, 4'h0);
      // Glitch of THRESH-1 rejected, THRESH accepted
      n = 0;
      repeat (7) begin step(1'b0, 4'h1, 1'b1, 1'b0); n += int'(rise[0]); end
      repeat (15) begin step(1'b0, 4'h0, 1'b1, 1'b0); n += int'(rise[0]); end
      chk("glitch7", 4'(n), 4'h0);
      n = 0;
      nf = 0;
      repeat (8) begin step(1'b0, 4'h1, 1'b1, 1'b0); n += int'(rise[0]); end
      for (int i = 1; i <= 15; i++) begin
         step(1'b0, 4'h0, 1'b1, 1'b0);
         n += int'(rise[0]);
         nf += int'(fall[0]);
         if (i == 10) chk("glitch8_fall", fall, 4'h1);
      end
      chk("glitch8_rise_cnt", 4'(n), 4'h1);
      chk("glitch8_fall_cnt", 4'(nf), 4'h1);
      // Bounce restarts the count
      repeat (5) step(1'b0, 4'h1, 1'b1, 1'b0);
      step(1'b0, 4'h0, 1'b1, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 4'h1, 1'b1, 1'b0);
         if (i == 9) chk("bounce_pre", debounced, 4'h0);
         if (i == 10) chk("bounce_rise", rise, 4'h1);
      end
      // Decimated sampling on ch1
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 4'h3, 1'(i % 4 == 0), 1'b0);
         if (i == 28) chk("tick_pre", debounced, 4'h1);
         if (i == 32) chk("tick_rise", rise, 4'h2);
      end
      // Hold mid-count on ch2
      n = 0;
      repeat (6) begin step(1'b0, 4'h7, 1'b1, 1'b0); n += int'(rise[2]); end
      repeat (3) begin step(1'b0, 4'h7, 1'b1, 1'b1); n += int'(rise[2]); end
      chk("hold_no_pulse", 4'(n), 4'h0);
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 4'h7, 1'b1, 1'b0);
         if (i == 7) chk("hold_pre", debounced, 4'h3);
         if (i == 8) chk("hold_rise", rise, 4'h4);
      end
      // Simultaneous rise on ch1 and fall on ch2
      repeat (12) step(1'b0, 4'h5, 1'b1, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 4'h3, 1'b1, 1'b0);
         if (i == 10) begin
            chk("sim_rise", rise, 4'h2);
            chk("sim_fall", fall, 4'h4);
            chk("sim_deb", debounced, 4'h3);
            chk("sim_any", {3'b000, any_change}, 4'h1);
         end
         if (i == 11) chk("sim_any_off", {3'b000, any_change}, 4'h0);
      end
      // Random traffic
      rl = 4'h3;
      repeat (600) begin
         for (int c = 0; c < CH; c++) if ($urandom_range(5) == 0) rl[c] = ~rl[c];
         step(1'($urandom_range(199) == 0), rl, 1'($urandom_range(4) != 0), 1'($urandom_range(39) == 0));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
